// File: rtl/uart_framer_pkg.sv
// rtl/uart_framer_pkg.sv - shared state type and constants for the UART result framer
package uart_framer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    SEQ,
    DATA,
    CSUM
  } framer_state_e;

  localparam logic [7:0] FramerSof      = 8'hA5;
  localparam int         FramerOverhead = 3;

endpackage

// File: rtl/uart_result_framer.sv
// rtl/uart_result_framer.sv - frames each product as SOF, SEQ, data bytes MSB first, XOR checksum
module uart_result_framer
  import uart_framer_pkg::*;
#(
  parameter int         width_p = 32,
  parameter logic [7:0] sof_p   = FramerSof
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               yumi_o,
  output logic               v_o,
  output logic [7:0]         data_o,
  input  logic               ready_and_i,
  output logic               busy_o,
  output logic [7:0]         seq_o
);

  localparam int N    = width_p / 8;
  localparam int CntW = (N > 1) ? $clog2(N) : 1;

  framer_state_e      state_r;
  logic [width_p-1:0] prod_r;
  logic [7:0]         csum_r;
  logic [7:0]         seq_r;
  logic [CntW-1:0]    cnt_r;
  logic [CntW-1:0]    byte_idx;
  logic [7:0]         cur_byte;

  // Bytes leave MSB first, so the counter walks the product from the top down.
  assign byte_idx = CntW'(N - 1) - cnt_r;
  assign cur_byte = prod_r[{byte_idx, 3'b000} +: 8];

  assign v_o    = (state_r != IDLE);
  assign busy_o = (state_r != IDLE);
  assign yumi_o = (state_r == IDLE) & v_i & ~reset_i;
  assign seq_o  = seq_r;

  always_comb begin
    data_o = sof_p;
    case (state_r)
      SEQ:     data_o = seq_r;
      DATA:    data_o = cur_byte;
      CSUM:    data_o = csum_r;
      default: data_o = sof_p;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      prod_r  <= '0;
      csum_r  <= '0;
      seq_r   <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (v_i) begin
            prod_r  <= data_i;
            csum_r  <= '0;
            state_r <= SOF;
          end
        end
        SOF: begin
          if (ready_and_i) state_r <= SEQ;
        end
        SEQ: begin
          if (ready_and_i) begin
            csum_r  <= seq_r;
            cnt_r   <= '0;
            state_r <= DATA;
          end
        end
        DATA: begin
          if (ready_and_i) begin
            csum_r <= csum_r ^ cur_byte;
            cnt_r  <= cnt_r + CntW'(1);
            if (cnt_r == CntW'(N - 1)) state_r <= CSUM;
          end
        end
        CSUM: begin
          if (ready_and_i) begin
            seq_r   <= seq_r + 8'd1;
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_result_framer.sv
// tb/tb_uart_result_framer.sv - randomized self-checking bench for uart_result_framer
module tb_uart_result_framer;
  import uart_framer_pkg::*;

  localparam int WIDTH = 32;
  localparam int NB    = WIDTH / 8;

  logic             clk = 1'b0;
  logic             reset_i;
  logic             v_i;
  logic [WIDTH-1:0] data_i;
  logic             yumi_o;
  logic             v_o;
  logic [7:0]       data_o;
  logic             ready_and_i;
  logic             busy_o;
  logic [7:0]       seq_o;

  uart_result_framer #(.width_p(WIDTH), .sof_p(8'hA5)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .data_i      (data_i),
    .yumi_o      (yumi_o),
    .v_o         (v_o),
    .data_o      (data_o),
    .ready_and_i (ready_and_i),
    .busy_o      (busy_o),
    .seq_o       (seq_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [WIDTH-1:0] prod_q[$];
  logic [7:0]       exp_q[$];
  bit               last_q[$];
  logic [7:0]       got_q[$];
  int               yumi_cyc_q[$];
  logic [7:0]       model_seq = 8'h00;
  int               duty = 100;
  int               cyc = 0;
  int               last_csum_cyc = -10;
  bit               stall_prev = 1'b0;
  bit               yumi_prev = 1'b0;
  bit               post_reset = 1'b0;
  logic [7:0]       stall_byte = 8'h00;

  logic [7:0] ref12 [14] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08,
                             8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};

  // Reference frame: SOF, seq, bytes MSB first, XOR of seq and data bytes.
  function automatic void push_frame(input logic [WIDTH-1:0] p);
    logic [7:0] cs;
    logic [7:0] b;
    cs = model_seq;
    exp_q.push_back(8'hA5);    last_q.push_back(1'b0);
    exp_q.push_back(model_seq); last_q.push_back(1'b0);
    for (int i = NB - 1; i >= 0; i--) begin
      b  = p[8*i +: 8];
      cs = cs ^ b;
      exp_q.push_back(b); last_q.push_back(1'b0);
    end
    exp_q.push_back(cs); last_q.push_back(1'b1);
    model_seq = model_seq + 8'd1;
  endfunction

  task automatic drive();
    v_i         = (prod_q.size() > 0);
    data_i      = v_i ? prod_q[0] : WIDTH'($urandom);
    ready_and_i = (int'($urandom_range(99)) < duty);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (reset_i) begin
      check("rst_yumi", yumi_o, 1'b0);
      yumi_prev  = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (post_reset) begin
        check("rst_v_o", v_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_seq", seq_o, 8'h00);
        check("rst_data", data_o, 8'hA5);
        post_reset = 1'b0;
      end
      if (yumi_prev) begin
        check("lat_v", v_o, 1'b1);
        check("lat_sof", data_o, 8'hA5);
      end
      if (stall_prev) begin
        check("stall_v", v_o, 1'b1);
        check("stall_data", data_o, stall_byte);
      end
      if (cyc == last_csum_cyc + 1) begin
        check("idle_gap", v_o, 1'b0);
        if (v_i) check("b2b_yumi", yumi_o, 1'b1);
      end
      if (v_o) check("yumi_in_frame", yumi_o, 1'b0);
      if (yumi_o) begin
        check("yumi_needs_v", v_i, 1'b1);
        check("seq_o", seq_o, model_seq);
        yumi_cyc_q.push_back(cyc);
        if (prod_q.size() > 0) begin
          push_frame(prod_q[0]);
          void'(prod_q.pop_front());
        end
      end
      if (v_o && ready_and_i) begin
        got_q.push_back(data_o);
        check("byte_expected", (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) begin
          check("byte", data_o, exp_q.pop_front());
          if (last_q.pop_front()) last_csum_cyc = cyc;
        end
      end
      yumi_prev  = yumi_o;
      stall_prev = v_o && !ready_and_i;
      stall_byte = data_o;
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((prod_q.size() > 0 || exp_q.size() > 0) && n < limit) begin
      tick();
      n++;
    end
    check("drain_done", (prod_q.size() == 0 && exp_q.size() == 0), 1'b1);
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    exp_q.delete();
    last_q.delete();
    model_seq     = 8'h00;
    last_csum_cyc = -10;
    post_reset    = 1'b1;
  endtask

  initial begin
    reset_i     = 1'b1;
    v_i         = 1'b0;
    data_i      = '0;
    ready_and_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset with a product already waiting, then two frames back to back.
    duty = 100;
    prod_q.push_back(32'h12345678);
    prod_q.push_back(32'hDEADBEEF);
    drive();
    pulse_reset();
    got_q.delete();
    yumi_cyc_q.delete();
    drain(100);
    tick();
    check("idle_busy", busy_o, 1'b0);
    check("b2b_len", got_q.size(), 14);
    for (int i = 0; i < 14 && i < got_q.size(); i++) check("b2b_ref", got_q[i], ref12[i]);
    check("yumi_count", yumi_cyc_q.size(), 2);
    if (yumi_cyc_q.size() == 2) check("frame_period", yumi_cyc_q[1] - yumi_cyc_q[0], NB + 4);

    // Random backpressure on the first frame again.
    pulse_reset();
    duty = 50;
    got_q.delete();
    prod_q.push_back(32'h12345678);
    drain(400);
    check("stall_len", got_q.size(), 7);
    for (int i = 0; i < 7 && i < got_q.size(); i++) check("stall_ref", got_q[i], ref12[i]);

    // New product arrives mid-frame, plus random traffic.
    for (int f = 0; f < 12; f++) begin
      duty = int'($urandom_range(30, 100));
      prod_q.push_back(WIDTH'($urandom));
      for (int k = 0; k < 40 && exp_q.size() < 5; k++) tick();
      repeat (int'($urandom_range(1, 3))) tick();
      prod_q.push_back(WIDTH'($urandom));
      drain(800);
    end

    // Reset while DATA bytes are leaving; product re-presented afterwards.
    duty = 100;
    got_q.delete();
    prod_q.push_back(32'h12345678);
    for (int k = 0; k < 40 && got_q.size() < 4; k++) tick();
    check("pre_reset_busy", busy_o, 1'b1);
    prod_q.delete();
    prod_q.push_back(32'h12345678);
    drive();
    pulse_reset();
    got_q.delete();
    drain(100);
    check("rerun_len", got_q.size(), 7);
    for (int i = 0; i < 7 && i < got_q.size(); i++) check("rerun_ref", got_q[i], ref12[i]);

    // 256 zero frames: sequence wraps and each checksum equals its seq byte.
    pulse_reset();
    got_q.delete();
    for (int f = 0; f < 256; f++) prod_q.push_back('0);
    drain(4000);
    tick();
    check("wrap_seq_o", seq_o, 8'h00);
    check("wrap_len", got_q.size(), 256 * 7);
    if (got_q.size() == 256 * 7) begin
      check("wrap_seq_ff", got_q[255*7 + 1], 8'hFF);
      check("wrap_csum_ff", got_q[255*7 + 6], 8'hFF);
      check("wrap_csum_7f", got_q[127*7 + 6], 8'h7F);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
